// File: rtl/prod_accum.sv
// Frame accumulator behind the 2x2 multiplier: sums 4-bit products per frame and hands the total out on valid/ready.
// Optional macro PROD_ACCUM_SAT_EN: saturate the accumulator instead of wrapping.
//
// state | meaning
// IDLE  | no frame in progress, acc/cnt/ovf cleared
// ACC   | frame in progress, waiting for more beats
// DONE  | holding a completed frame result
module prod_accum #(
  parameter int ACC_W     = 8,
  parameter int MAX_BEATS = 16,
  parameter int CNT_W     = $clog2(MAX_BEATS + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_prod,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_sum,
  output logic [CNT_W-1:0] out_count,
  output logic             out_ovf
);

  typedef enum logic [1:0] {IDLE, ACC, DONE} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_BEATS);

  state_t           state;
  logic [ACC_W-1:0] acc;
  logic [CNT_W-1:0] cnt;
  logic             ovf;

  logic [ACC_W:0]   sum_ext;
  logic             carry;
  logic [ACC_W-1:0] acc_nxt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             beat;
  logic             close;

  assign in_ready = (state != DONE);
  assign beat     = in_valid & in_ready;
  assign sum_ext  = {1'b0, acc} + {{(ACC_W-3){1'b0}}, in_prod};
  assign carry    = sum_ext[ACC_W];
  assign cnt_nxt  = cnt + CNT_W'(1);
  assign close    = in_last | (cnt_nxt == CNT_MAX);

`ifdef PROD_ACCUM_SAT_EN
  // once saturated, the sticky ovf keeps acc pinned for the rest of the frame
  assign acc_nxt = (carry | ovf) ? '1 : sum_ext[ACC_W-1:0];
`else
  assign acc_nxt = sum_ext[ACC_W-1:0];
`endif

  // the running registers double as the result registers; they freeze in DONE
  assign out_sum   = acc;
  assign out_count = cnt;
  assign out_ovf   = ovf;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      acc       <= '0;
      cnt       <= '0;
      ovf       <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE, ACC: begin
          if (beat) begin
            acc <= acc_nxt;
            cnt <= cnt_nxt;
            ovf <= ovf | carry;
            if (close) begin
              state     <= DONE;
              out_valid <= 1'b1;
            end else begin
              state <= ACC;
            end
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            acc       <= '0;
            cnt       <= '0;
            ovf       <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_prod_accum.sv
// Self-checking bench for prod_accum: vector table, corner-case sequences and a randomized run against a frame model.
module tb_prod_accum;

  localparam int ACC_W     = 6;
  localparam int MAX_BEATS = 10;
  localparam int CNT_W     = 4;
  localparam int ACC_MAX   = (1 << ACC_W) - 1;

`ifdef PROD_ACCUM_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [3:0]       in_prod = '0;
  logic             in_last = 1'b0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [ACC_W-1:0] out_sum;
  logic [CNT_W-1:0] out_count;
  logic             out_ovf;

  prod_accum #(.ACC_W(ACC_W), .MAX_BEATS(MAX_BEATS), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_prod(in_prod), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_count(out_count), .out_ovf(out_ovf)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // n beats: first n-1 carry val, the final one carries last_val
  typedef struct {
    int n;
    int val;
    int last_val;
    bit last;
    int sum;
    int cnt;
    bit ovf;
  } vec_t;

  function automatic vec_t mk(int n, int val, int last_val, bit last, int sum, int cnt, bit ovf);
    vec_t v;
    v.n = n; v.val = val; v.last_val = last_val; v.last = last;
    v.sum = sum; v.cnt = cnt; v.ovf = ovf;
    return v;
  endfunction

  task automatic run_vec(input vec_t v);
    out_ready = 1'b1;
    for (int i = 0; i < v.n; i++) begin
      in_valid = 1'b1;
      in_prod  = (i == v.n - 1) ? 4'(v.last_val) : 4'(v.val);
      in_last  = v.last && (i == v.n - 1);
      chk("vec_ready", int'(in_ready), 1);
      chk("vec_open", int'(out_valid), 0);
      tick();
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    chk("vec_valid", int'(out_valid), 1);
    chk("vec_sum", int'(out_sum), v.sum);
    chk("vec_count", int'(out_count), v.cnt);
    chk("vec_ovf", int'(out_ovf), int'(v.ovf));
    tick();
    chk("vec_handshake_valid", int'(out_valid), 0);
    chk("vec_handshake_ready", int'(in_ready), 1);
  endtask

  vec_t vecs[8];

  bit   m_hold;
  int   m_q[$];
  int   total;

  initial begin
    vecs[0] = mk(3, 9, 4, 1'b1, 22, 3, 1'b0);
    vecs[1] = mk(10, 6, 6, 1'b0, 60, 10, 1'b0);
    vecs[2] = mk(6, 9, 4, 1'b1, 49, 6, 1'b0);
    vecs[3] = mk(9, 9, 9, 1'b1, SAT ? 63 : 17, 9, 1'b1);
    vecs[4] = mk(1, 1, 1, 1'b1, 1, 1, 1'b0);
    vecs[5] = mk(10, 9, 9, 1'b0, SAT ? 63 : 26, 10, 1'b1);
    vecs[6] = mk(10, 1, 1, 1'b1, 10, 10, 1'b0);
    vecs[7] = mk(2, 15, 15, 1'b1, 30, 2, 1'b0);

    #2;
    chk("rst_valid", int'(out_valid), 0);
    chk("rst_sum", int'(out_sum), 0);
    chk("rst_count", int'(out_count), 0);
    chk("rst_ovf", int'(out_ovf), 0);
    #10 rst_n = 1'b1;
    tick();
    chk("rst_ready", int'(in_ready), 1);

    foreach (vecs[i]) run_vec(vecs[i]);

    // auto-close with backpressure: pending beat must stall until the handshake
    out_ready = 1'b0;
    for (int i = 0; i < MAX_BEATS; i++) begin
      in_valid = 1'b1; in_prod = 4'd6; in_last = 1'b0;
      tick();
    end
    in_prod = 4'd3; in_last = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk("bp_ready_low", int'(in_ready), 0);
      chk("bp_valid", int'(out_valid), 1);
      chk("bp_sum_stable", int'(out_sum), 60);
      chk("bp_count_stable", int'(out_count), 10);
      tick();
    end
    out_ready = 1'b1;
    tick();
    chk("bp_release_valid", int'(out_valid), 0);
    chk("bp_release_ready", int'(in_ready), 1);
    tick();
    in_valid = 1'b0; in_last = 1'b0;
    chk("bp_next_valid", int'(out_valid), 1);
    chk("bp_next_sum", int'(out_sum), 3);
    chk("bp_next_count", int'(out_count), 1);
    tick();

    // gaps hold the frame open; junk on the inputs is ignored while in_valid=0
    in_valid = 1'b1; in_prod = 4'd2; in_last = 1'b0;
    tick();
    in_valid = 1'b0; in_prod = 4'd9; in_last = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("gap_open", int'(out_valid), 0);
    end
    in_valid = 1'b1; in_prod = 4'd7; in_last = 1'b1;
    tick();
    in_valid = 1'b0; in_last = 1'b0;
    chk("gap_valid", int'(out_valid), 1);
    chk("gap_sum", int'(out_sum), 9);
    chk("gap_count", int'(out_count), 2);
    tick();

    // asynchronous reset mid-frame
    in_valid = 1'b1; in_prod = 4'd9; in_last = 1'b0;
    tick();
    tick();
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("amid_sum", int'(out_sum), 0);
    chk("amid_count", int'(out_count), 0);
    chk("amid_valid", int'(out_valid), 0);
    chk("amid_ovf", int'(out_ovf), 0);
    @(negedge clk) rst_n = 1'b1;
    tick();
    in_valid = 1'b1; in_prod = 4'd4; in_last = 1'b1;
    tick();
    in_valid = 1'b0; in_last = 1'b0;
    chk("post_rst_valid", int'(out_valid), 1);
    chk("post_rst_sum", int'(out_sum), 4);
    chk("post_rst_count", int'(out_count), 1);
    tick();

    // randomized traffic against a frame-level model
    m_hold = 1'b0;
    m_q.delete();
    for (int c = 0; c < 3000; c++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_prod   = 4'($urandom_range(0, 15));
      in_last   = ($urandom_range(0, 4) == 0);
      out_ready = ($urandom_range(0, 2) != 0);
      if (m_hold) begin
        if (out_ready) begin
          m_hold = 1'b0;
          m_q.delete();
        end
      end else if (in_valid) begin
        m_q.push_back(int'(in_prod));
        if (in_last || m_q.size() == MAX_BEATS) m_hold = 1'b1;
      end
      tick();
      chk("rnd_valid", int'(out_valid), int'(m_hold));
      chk("rnd_ready", int'(in_ready), int'(!m_hold));
      if (m_hold) begin
        total = m_q.sum();
        chk("rnd_sum", int'(out_sum), SAT ? ((total > ACC_MAX) ? ACC_MAX : total) : (total % (ACC_MAX + 1)));
        chk("rnd_count", int'(out_count), m_q.size());
        chk("rnd_ovf", int'(out_ovf), int'(total > ACC_MAX));
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
